// File: rtl/iir_filter_mc_if.sv
// Sample/result bus of the multichannel biquad; ovf exists only when IIR_SAT_EN is defined.
interface iir_filter_mc_if #(
  parameter int NB  = 12,
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic                 vIn;
  logic signed [NB-1:0] dIn;
  logic [CW-1:0]        chIn;
  logic [3*NB-1:0]      b;
  logic [2*NB-1:0]      a;
  logic                 flush;
  logic signed [NB-1:0] dOut;
  logic                 vOut;
  logic [CW-1:0]        chOut;
`ifdef IIR_SAT_EN
  logic                 ovf;
`endif

  modport master (
    output vIn, dIn, chIn, b, a, flush,
    input  dOut, vOut, chOut
`ifdef IIR_SAT_EN
    , input ovf
`endif
  );

  modport slave (
    input  vIn, dIn, chIn, b, a, flush,
    output dOut, vOut, chOut
`ifdef IIR_SAT_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/iir_filter_mc.sv
// Time-multiplexed direct-form-II biquad, NCH channels sharing one coefficient set.
// Define IIR_SAT_EN for saturating width reduction of w/y plus the ovf flag; default wraps.
module iir_filter_mc #(
  parameter int NB  = 12,
  parameter int NCH = 4
) (
  input logic            clk,
  input logic            rst,
  iir_filter_mc_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int SW = 2*NB + 2;
  localparam logic signed [SW-1:0] SAT_HI = {{(SW-NB+1){1'b0}}, {(NB-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-NB+1){1'b1}}, {(NB-1){1'b0}}};

  function automatic logic signed [2*NB-1:0] mul(input logic signed [NB-1:0] p,
                                                 input logic signed [NB-1:0] q);
    logic signed [2*NB-1:0] pe;
    logic signed [2*NB-1:0] qe;
    pe = {{NB{p[NB-1]}}, p};
    qe = {{NB{q[NB-1]}}, q};
    return pe * qe;
  endfunction

  function automatic logic signed [SW-1:0] ext(input logic signed [2*NB-1:0] p);
    return {{2{p[2*NB-1]}}, p};
  endfunction

  logic                 s1_v;
  logic signed [NB-1:0] s1_d;
  logic [CW-1:0]        s1_ch;
  logic [3*NB-1:0]      s1_b;
  logic [2*NB-1:0]      s1_a;

  logic signed [NB-1:0] w1_q [NCH];
  logic signed [NB-1:0] w2_q [NCH];

  logic                 vout_q;
  logic signed [NB-1:0] dout_q;
  logic [CW-1:0]        chout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_d  <= '0;
      s1_ch <= '0;
      s1_b  <= '0;
      s1_a  <= '0;
    end else begin
      s1_v <= bus.vIn;
      if (bus.vIn) begin
        s1_d  <= bus.dIn;
        s1_ch <= bus.chIn;
        s1_b  <= bus.b;
        s1_a  <= bus.a;
      end
    end
  end

  logic signed [NB-1:0] b0_c, b1_c, b2_c, a1_c, a2_c;
  assign b0_c = s1_b[NB-1:0];
  assign b1_c = s1_b[2*NB-1:NB];
  assign b2_c = s1_b[3*NB-1:2*NB];
  assign a1_c = s1_a[NB-1:0];
  assign a2_c = s1_a[2*NB-1:NB];

  // A flush in the same cycle makes the stage-2 sample see an already-cleared state.
  logic signed [NB-1:0] w1_rd, w2_rd;
  always_comb begin
    w1_rd = '0;
    w2_rd = '0;
    if (!bus.flush) begin
      w1_rd = w1_q[s1_ch];
      w2_rd = w2_q[s1_ch];
    end
  end

  logic signed [SW-1:0] x_sh, w_sum, w_shr, y_sum, y_shr;
  logic signed [NB-1:0] w_val, y_val;

  assign x_sh  = $signed({{(NB+2){s1_d[NB-1]}}, s1_d}) <<< (NB-1);
  assign w_sum = x_sh - ext(mul(a1_c, w1_rd)) - ext(mul(a2_c, w2_rd));
  assign w_shr = w_sum >>> (NB-1);

  assign y_sum = ext(mul(b0_c, w_val)) + ext(mul(b1_c, w1_rd)) + ext(mul(b2_c, w2_rd));
  assign y_shr = y_sum >>> (NB-1);

`ifdef IIR_SAT_EN
  logic w_hi, w_lo, y_hi, y_lo, sat_hit, ovf_q;
  assign w_hi    = (w_shr > SAT_HI);
  assign w_lo    = (w_shr < SAT_LO);
  assign y_hi    = (y_shr > SAT_HI);
  assign y_lo    = (y_shr < SAT_LO);
  assign w_val   = w_hi ? SAT_HI[NB-1:0] : (w_lo ? SAT_LO[NB-1:0] : w_shr[NB-1:0]);
  assign y_val   = y_hi ? SAT_HI[NB-1:0] : (y_lo ? SAT_LO[NB-1:0] : y_shr[NB-1:0]);
  assign sat_hit = w_hi | w_lo | y_hi | y_lo;
`else
  // Wrapping keeps only the low NB bits; the guard bits are intentionally dropped.
  logic unused_guard;
  assign w_val        = w_shr[NB-1:0];
  assign y_val        = y_shr[NB-1:0];
  assign unused_guard = ^{w_shr[SW-1:NB], y_shr[SW-1:NB], SAT_HI[0], SAT_LO[0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vout_q  <= 1'b0;
      dout_q  <= '0;
      chout_q <= '0;
`ifdef IIR_SAT_EN
      ovf_q   <= 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else begin
      vout_q <= s1_v;
      if (s1_v) begin
        dout_q  <= y_val;
        chout_q <= s1_ch;
`ifdef IIR_SAT_EN
        ovf_q   <= sat_hit;
`endif
      end
      if (bus.flush) begin
        for (int i = 0; i < NCH; i++) begin
          w1_q[i] <= '0;
          w2_q[i] <= '0;
        end
      end else if (s1_v) begin
        w1_q[s1_ch] <= w_val;
        w2_q[s1_ch] <= w1_rd;
      end
    end
  end

  assign bus.vOut  = vout_q;
  assign bus.dOut  = dout_q;
  assign bus.chOut = chout_q;
`ifdef IIR_SAT_EN
  assign bus.ovf   = ovf_q;
`endif
endmodule
